// File: rtl/tx_module.sv
// tx_module: RS232 byte transmitter, 8N1 framing with registered line and done outputs.
// Define TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module tx_module #(
  parameter int BPS_CNT = 434
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       TX_En_Sig,
  input  logic [7:0] TX_Data,
  output logic       TX_Done_Sig,
  output logic       TX_Pin_Out
);
  localparam int CW = BPS_CNT > 2 ? $clog2(BPS_CNT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(BPS_CNT - 1);
`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE, WAIT_LOW} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE, WAIT_LOW} state_t;
`endif
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_idx;
  logic [7:0] r_shift;
  logic r_pin, r_done, w_pin, w_done, w_bit_end, w_idle;
  assign w_bit_end = r_cnt == C_LAST;
  assign w_idle = r_state == IDLE || r_state == DONE || r_state == WAIT_LOW;
  assign TX_Pin_Out = r_pin;
  assign TX_Done_Sig = r_done;
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_idx <= '0;
      r_shift <= '0;
      r_pin <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_bit_end || w_idle || w_next != r_state) ? '0 : r_cnt + 1'b1;
      r_idx <= (r_state == DATA) ? r_idx + {2'b0, w_bit_end} : '0;
      if (r_state == IDLE && TX_En_Sig) r_shift <= TX_Data;
      r_pin <= w_pin;
      r_done <= w_done;
    end
  end
  always_comb begin
    w_next = r_state;
    w_pin = 1'b1;
    w_done = 1'b0;
    case (r_state)
      IDLE: w_next = TX_En_Sig ? START : IDLE;
      START: begin
        w_pin = 1'b0;
        w_next = w_bit_end ? DATA : START;
      end
      DATA: begin
        w_pin = r_shift[r_idx];
`ifdef TX_PARITY_EN
        w_next = (w_bit_end && r_idx == 3'd7) ? PARITY : DATA;
      end
      PARITY: begin
        w_pin = ^r_shift;
        w_next = w_bit_end ? STOP : PARITY;
`else
        w_next = (w_bit_end && r_idx == 3'd7) ? STOP : DATA;
`endif
      end
      STOP: w_next = w_bit_end ? DONE : STOP;
      DONE: begin
        w_done = 1'b1;
        w_next = WAIT_LOW;
      end
      WAIT_LOW: w_next = TX_En_Sig ? WAIT_LOW : IDLE;
      default: w_next = IDLE;
    endcase
  end
  a_bps_cnt: assert property (@(posedge CLK) BPS_CNT >= 2)
    else $fatal(1, "tx_module: BPS_CNT below 2 is unsupported");
endmodule

// File: tb/tb_tx_module.sv
// tb_tx_module: directed frame vectors plus reset and held-request sequences at BPS_CNT=4.
module tb_tx_module;
  localparam int BPS = 4;
`ifdef TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  typedef struct {
    logic [7:0] d;
    logic [9:0] f;
    logic p;
    int mode;
  } vec_t;
  logic CLK, RSTn, TX_En_Sig, TX_Done_Sig, TX_Pin_Out;
  logic [7:0] TX_Data;
  int n_pass = 0, n_tot = 0;
  vec_t v[7];
  tx_module #(.BPS_CNT(BPS)) dut (
    .CLK(CLK), .RSTn(RSTn), .TX_En_Sig(TX_En_Sig), .TX_Data(TX_Data),
    .TX_Done_Sig(TX_Done_Sig), .TX_Pin_Out(TX_Pin_Out)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask
  function automatic logic bitval(input vec_t x, input int j);
`ifdef TX_PARITY_EN
    return j < 9 ? x.f[j] : (j == 9 ? x.p : 1'b1);
`else
    return x.f[j];
`endif
  endfunction
  // Entered at a negedge; the next posedge is the request sampling edge (k=0).
  task automatic run_frame(input vec_t x, input string nm);
    logic early;
    early = 1'b0;
    TX_Data = x.d;
    TX_En_Sig = 1'b1;
    RSTn = 1'b1;
    for (int k = 0; k <= NB * BPS + 2; k++) begin
      @(negedge CLK);
      if (x.mode == 1 && k == 0) TX_Data = 8'hFF;
      if (x.mode == 2 && k == 5) TX_En_Sig = 1'b0;
      if (k == 0) chk({nm, " latency"}, TX_Pin_Out, 1);
      if (k >= 1 && k <= NB * BPS && (k - 1) % BPS == 1)
        chk($sformatf("%s bit%0d", nm, (k - 1) / BPS), TX_Pin_Out, bitval(x, (k - 1) / BPS));
      if (k <= NB * BPS && TX_Done_Sig) early = 1'b1;
      if (k == NB * BPS + 1) chk({nm, " done"}, TX_Done_Sig, 1);
      if (k == NB * BPS + 2) chk({nm, " done_one_cycle"}, TX_Done_Sig, 0);
    end
    chk({nm, " early_done"}, early, 0);
  endtask
  initial begin
    logic bad;
    v[0] = '{8'h55, 10'b1_01010101_0, 1'b0, 0};
    v[1] = '{8'hA3, 10'b1_10100011_0, 1'b0, 1};
    v[2] = '{8'h00, 10'b1_00000000_0, 1'b0, 0};
    v[3] = '{8'hFF, 10'b1_11111111_0, 1'b0, 0};
    v[4] = '{8'h07, 10'b1_00000111_0, 1'b1, 0};
    v[5] = '{8'h03, 10'b1_00000011_0, 1'b0, 2};
    v[6] = '{8'h80, 10'b1_10000000_0, 1'b1, 0};
    RSTn = 1'b0;
    TX_En_Sig = 1'b0;
    TX_Data = 8'h00;
    repeat (3) @(negedge CLK);
    chk("reset pin", TX_Pin_Out, 1);
    chk("reset done", TX_Done_Sig, 0);
    for (int i = 0; i < 7; i++) begin
      run_frame(v[i], $sformatf("vec%0d", i));
      TX_En_Sig = 1'b0;
      repeat (2) @(negedge CLK);
    end
    TX_Data = 8'h55;
    TX_En_Sig = 1'b1;
    for (int k = 0; k <= 18; k++) @(negedge CLK);
    chk("pre_reset d3", TX_Pin_Out, 0);
    RSTn = 1'b0;
    @(negedge CLK);
    chk("mid_reset pin", TX_Pin_Out, 1);
    chk("mid_reset done", TX_Done_Sig, 0);
    bad = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      if (TX_Done_Sig || !TX_Pin_Out) bad = 1'b1;
    end
    chk("in_reset quiet", bad, 0);
    run_frame(v[1], "post_reset");
    bad = 1'b0;
    repeat (100) begin
      @(negedge CLK);
      if (TX_Done_Sig || !TX_Pin_Out) bad = 1'b1;
    end
    chk("held_en single_frame", bad, 0);
    TX_En_Sig = 1'b0;
    repeat (2) @(negedge CLK);
    run_frame(v[0], "after_release");
    TX_En_Sig = 1'b0;
    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
